alu_issue_unit: RTL
===================

Name: alu_issue_unit

Overview:
- Sequencing stage directly upstream of the ALU. Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x32 register file and drives alu_op/r2/r3 into the combinational ALU.
- Captures the ALU's r1 result and writes it back to the destination register.
- Multi-cycle and non-pipelined: one instruction in flight at a time.

Parameters:
- NREG, 8, number of registers; register index width is fixed at 3 bits.
- DW, 32, data width; must match the ALU r1/r2/r3 width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  instruction word present.
- in_ready  output  1  unit can accept an instruction.
- instr  input  16  bits [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ignored. For op 111, bits [9:0] are an immediate.
- alu_op  output  3  registered operation code to the ALU.
- r2  output  DW  registered operand A = rf[rs].
- r3  output  DW  registered operand B = rf[rt].
- r1  input  DW  combinational ALU result.
- wb_valid  output  1  one-cycle pulse while the write-back is performed.
- wb_addr  output  3  destination register of the current write-back.
- wb_data  output  DW  value being written.
- dbg_addr  input  3  debug read address.
- dbg_data  output  DW  combinational rf[dbg_addr]; reflects the write one cycle after the wb_valid cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state <= IDLE; all rf entries <= 0.
  - alu_op, r2, r3, wb_addr, wb_data <= 0; wb_valid = 0.
  - in_ready is forced 0 while rst_n=0.
- Reset mid-operation: aborts the instruction with no write-back. The next instruction is accepted at the first edge after rst_n returns high.
- States: IDLE, LOAD, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge, latch the instr fields.
  - If op != 111: go to LOAD.
  - If op == 111 (LDI): res <= {22'b0, instr[9:0]}, go directly to WB. alu_op/r2/r3 keep their previous values.
- LOAD: at the exiting edge, alu_op <= op, r2 <= rf[rs], r3 <= rf[rt]. Go to EXEC.
- EXEC: ALU inputs are stable for the whole cycle. At the exiting edge, res <= r1. Go to WB.
- WB:
  - wb_valid=1, wb_addr=rd, wb_data=res.
  - At the exiting edge, rf[rd] <= res. Go to IDLE.
- in_ready=0 in LOAD, EXEC and WB. in_valid is ignored outside IDLE, and the upstream must hold instr until accepted.
- Latency, counted from the accept edge:
  - ALU op: wb_valid in cycle 3; register updated at edge 3.
  - LDI: wb_valid in cycle 1.
- Throughput: one ALU op per 4 cycles, one LDI per 2 cycles.
- Read-after-write: rf is read in LOAD, which is always at least one edge after the previous write-back. No hazard logic is required.
- Any combination of rd/rs/rt may be equal, including rd=rs=rt. Operands are sampled in LOAD before the write in WB.
- Register 0 is an ordinary writable register (not hardwired).
- Immediate is zero-extended. No sign extension and no overflow handling; all arithmetic belongs to the ALU.

Optional Feature:
- Macro: ALU_ISSUE_ZFLAG_EN.
- When defined:
  - Adds output port zero_flag (1 bit), reset to 0.
  - At each WB exiting edge, zero_flag <= (res == 0). This applies to LDI too.
  - Holds its value between write-backs.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → in_ready=0, wb_valid=0, alu_op/r2/r3=0, dbg_data=0 for all 8 addresses.
- LDI: instr = {3'b111, rd=1, 10'h3FF} accepted → wb_valid one cycle later with wb_addr=1, wb_data=0x000003FF; dbg_addr=1 reads 0x3FF afterwards.
- ALU op:
  - Setup: LDI r2=0x0F0, then instr = {3'b010, rd=3, rs=1, rt=2}.
  - During EXEC: alu_op=3'b010, r2=0x3FF, r3=0x0F0.
  - wb_valid 3 cycles after accept, with wb_data equal to the ALU r1 sampled in EXEC; rf[3] holds that value.
- Handshake: drive in_valid continuously with 3 queued instructions → in_ready high only in IDLE; exactly 3 wb_valid pulses, spaced 4 cycles apart for ALU ops and 2 apart for LDI.
- Aliasing: rd=rs=rt=1 with op 3'b100 → r2=r3=old rf[1]; rf[1] is replaced only at the WB edge.
- Reset in EXEC: assert rst_n=0 for 1 cycle → no wb_valid pulse, all rf entries 0, next LDI completes normally. With ALU_ISSUE_ZFLAG_EN defined: LDI value 0 → zero_flag=1; LDI value 5 → zero_flag=0.

Source files
------------

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: multi-cycle issue stage in front of a combinational ALU.
// Accepts one 16-bit instruction at a time, reads operands from an internal
// register file, drives the ALU, and writes the ALU result (or a zero-extended
// 10-bit immediate for op 111) back to the destination register.
// Optional feature: define ALU_ISSUE_ZFLAG_EN to add the zero_flag output,
// which records whether the most recent written-back value was zero.
module alu_issue_unit #(
  parameter int NREG = 8,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] r3,
  input  logic [DW-1:0] r1,
  output logic          wb_valid,
  output logic [2:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef ALU_ISSUE_ZFLAG_EN
  ,
  output logic          zero_flag
`endif
);

  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    WB
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    rd_q, rd_d;
  logic [2:0]    rs_q, rs_d;
  logic [2:0]    rt_q, rt_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [DW-1:0] r2_q, r2_d;
  logic [DW-1:0] r3_q, r3_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
`ifdef ALU_ISSUE_ZFLAG_EN
  logic          zflag_q, zflag_d;
`endif

  // Low nibble of the instruction word carries no information.
  logic unused_instr;
  assign unused_instr = ^instr[3:0];

  assign in_ready = rst_n && (state_q == IDLE);
  assign alu_op   = alu_op_q;
  assign r2       = r2_q;
  assign r3       = r3_q;
  assign wb_valid = (state_q == WB);
  assign wb_addr  = rd_q;
  assign wb_data  = res_q;
  assign dbg_data = rf_q[dbg_addr];
`ifdef ALU_ISSUE_ZFLAG_EN
  assign zero_flag = zflag_q;
`endif

  // Next-state logic: decode on accept, read operands, capture result, write back.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    alu_op_d = alu_op_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    res_d    = res_q;
    rf_d     = rf_q;
`ifdef ALU_ISSUE_ZFLAG_EN
    zflag_d  = zflag_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d = instr[15:13];
          rd_d = instr[12:10];
          rs_d = instr[9:7];
          rt_d = instr[6:4];
          if (instr[15:13] == OP_LDI) begin
            // Immediate skips the ALU entirely; ALU-facing registers keep their values.
            res_d   = {{(DW-10){1'b0}}, instr[9:0]};
            state_d = WB;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        alu_op_d = op_q;
        r2_d     = rf_q[rs_q];
        r3_d     = rf_q[rt_q];
        state_d  = EXEC;
      end
      EXEC: begin
        res_d   = r1;
        state_d = WB;
      end
      WB: begin
        rf_d[rd_q] = res_q;
`ifdef ALU_ISSUE_ZFLAG_EN
        zflag_d    = (res_q == '0);
`endif
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      alu_op_q <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      res_q    <= '0;
      rf_q     <= '{default: '0};
`ifdef ALU_ISSUE_ZFLAG_EN
      zflag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      alu_op_q <= alu_op_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      res_q    <= res_d;
      rf_q     <= rf_d;
`ifdef ALU_ISSUE_ZFLAG_EN
      zflag_q  <= zflag_d;
`endif
    end
  end

endmodule
